// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared widths, port indices and write-request type for reg_write_arbiter
package reg_arb_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - writeback source ports and register-file write port bundle
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              VALID0;
    logic [ADDR_W-1:0] ADDR0;
    logic [DATA_W-1:0] DATA0;
    logic              READY0;
    logic              VALID1;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] DATA1;
    logic              READY1;
    logic              WRITE;
    logic [ADDR_W-1:0] INADDRESS;
    logic [DATA_W-1:0] IN;
    logic              GNT;
    logic              BUSY;

    modport master (
        output VALID0, ADDR0, DATA0, VALID1, ADDR1, DATA1,
        input  READY0, READY1, WRITE, INADDRESS, IN, GNT, BUSY
    );

    modport slave (
        input  VALID0, ADDR0, DATA0, VALID1, ADDR1, DATA1,
        output READY0, READY1, WRITE, INADDRESS, IN, GNT, BUSY
    );
endinterface

// File: rtl/wr_slot.sv
// rtl/wr_slot.sv - one-entry write holding slot with valid/ready accept and drain strobe
module wr_slot
    import reg_arb_pkg::*;
#(
    parameter type req_t = wr_req_t
) (
    input  logic CLK,
    input  logic RESET,
    input  logic valid,
    input  req_t req_in,
    input  logic drain,
    output logic ready,
    output logic pend,
    output req_t req_out
);

    // No bypass: a draining slot only reopens on the following cycle.
    assign ready = ~pend & ~RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend    <= 1'b0;
            req_out <= '0;
        end else if (drain) begin
            pend <= 1'b0;
        end else if (valid && ready) begin
            pend    <= 1'b1;
            req_out <= req_in;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-port round-robin arbiter for the register-file write port (REG_WRITE_ARB_FIXED_PRIO_EN selects fixed priority)
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RESET,
    reg_write_arbiter_if.slave      bus
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              req0_in, req1_in, slot0, slot1;
    logic              pend0, pend1;
    logic              drain0, drain1;
    logic              any_pend, sel, last;
    logic              write_q, gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    assign req0_in = {bus.ADDR0, bus.DATA0};
    assign req1_in = {bus.ADDR1, bus.DATA1};

    wr_slot #(.req_t(req_t)) u_slot0 (
        .CLK(CLK), .RESET(RESET), .valid(bus.VALID0), .req_in(req0_in),
        .drain(drain0), .ready(bus.READY0), .pend(pend0), .req_out(slot0)
    );

    wr_slot #(.req_t(req_t)) u_slot1 (
        .CLK(CLK), .RESET(RESET), .valid(bus.VALID1), .req_in(req1_in),
        .drain(drain1), .ready(bus.READY1), .pend(pend1), .req_out(slot1)
    );

    always_comb begin
        sel = PORT_ALU;
        if (pend0 && pend1) begin
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
            sel = PORT_ALU;
`else
            sel = ~last;
`endif
        end else if (pend1) begin
            sel = PORT_AUX;
        end
        any_pend = pend0 | pend1;
        drain0   = any_pend & (sel == PORT_ALU);
        drain1   = any_pend & (sel == PORT_AUX);
    end

    // LAST resets to port 1 so the first tie goes to port 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt_q   <= PORT_ALU;
            last    <= PORT_AUX;
        end else if (any_pend) begin
            write_q <= 1'b1;
            addr_q  <= (sel == PORT_AUX) ? slot1.addr : slot0.addr;
            data_q  <= (sel == PORT_AUX) ? slot1.data : slot0.data;
            gnt_q   <= sel;
            last    <= sel;
        end else begin
            write_q <= 1'b0;
        end
    end

    assign bus.WRITE     = write_q;
    assign bus.INADDRESS = addr_q;
    assign bus.IN        = data_q;
    assign bus.GNT       = gnt_q;
    assign bus.BUSY      = pend0 | pend1 | write_q;

endmodule
